// File: rtl/uart_tx_fifo_if.sv
// Producer / transmitter handshake bundle for uart_tx_fifo.
// The slave modport is the FIFO; the master modport is whatever feeds it and consumes its offers.
interface uart_tx_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    logic                 i_wr;
    logic [WIDTH-1:0]     i_wr_data;
    logic                 o_full;
    logic                 o_empty;
    logic [ADDR_BITS:0]   o_count;
    logic                 o_overflow;
    logic                 i_next;
    logic [WIDTH-1:0]     o_data;
    logic                 o_ready;

    modport master (
        output i_wr, i_wr_data, i_next,
        input  o_full, o_empty, o_count, o_overflow, o_data, o_ready
    );

    modport slave (
        input  i_wr, i_wr_data, i_next,
        output o_full, o_empty, o_count, o_overflow, o_data, o_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_tx: offers the head byte while the transmitter
// idles and pops it only once the transmitter drops o_next.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic          i_divided_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    uart_tx_fifo_if.slave bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    localparam logic [ADDR_BITS:0]   CNT_FULL  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ZERO  = (ADDR_BITS + 1)'(0);
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ZERO  = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] PTR_ONE   = ADDR_BITS'(1);
    localparam logic [WIDTH-1:0]     DATA_ZERO = WIDTH'(0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_r;
    logic [ADDR_BITS-1:0] rd_ptr_r;
    logic [ADDR_BITS:0]   count_r;
    logic [ADDR_BITS:0]   count_nxt_s;
    logic                 overflow_r;
    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     data_r;
    logic [WIDTH-1:0]     data_nxt_s;
    logic                 ready_r;
    logic                 ready_nxt_s;
    logic                 flush_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 wr_accept_s;
    logic                 wr_drop_s;
    logic                 pop_s;

    // Occupancy flags and write qualification; a flush swallows any same-cycle write.
    always_comb begin
        flush_s     = i_rst | i_clear;
        full_s      = (count_r == CNT_FULL);
        empty_s     = (count_r == CNT_ZERO);
        wr_accept_s = bus.i_wr & ~full_s & ~flush_s;
        wr_drop_s   = bus.i_wr &  full_s & ~flush_s;
    end

    // Handshake FSM: offer the head byte while the transmitter waits, pop once it has latched.
    always_comb begin
        state_nxt_s = state_r;
        ready_nxt_s = ready_r;
        data_nxt_s  = data_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_nxt_s = 1'b0;
                if (bus.i_next && !empty_s) begin
                    data_nxt_s  = mem_r[rd_ptr_r];
                    ready_nxt_s = 1'b1;
                    state_nxt_s = ST_OFFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (!bus.i_next) begin
                    pop_s       = 1'b1;
                    ready_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    ready_nxt_s = 1'b1;
                    state_nxt_s = ST_OFFER;
                end
            end
            default: begin
                ready_nxt_s = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Occupancy update: a write and a pop in the same cycle cancel out.
    always_comb begin
        case ({wr_accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; only accepted writes land, and it needs no reset since count gates reads.
    always_ff @(posedge i_divided_clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r] <= bus.i_wr_data;
        end
    end

    // Control and output registers; reset and clear share the same flush.
    always_ff @(posedge i_divided_clk) begin
        if (flush_s) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            overflow_r <= 1'b0;
            state_r    <= ST_IDLE;
            data_r     <= DATA_ZERO;
            ready_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            ready_r <= ready_nxt_s;
            count_r <= count_nxt_s;
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // Sticky: a dropped byte is flagged even if a pop frees a slot this cycle.
            if (wr_drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.o_full     = full_s;
    assign bus.o_empty    = empty_s;
    assign bus.o_count    = count_r;
    assign bus.o_overflow = overflow_r;
    assign bus.o_data     = data_r;
    assign bus.o_ready    = ready_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle vectors for handshake timing plus a
// transmitter model that checks delivered bytes against a scoreboard queue.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst;
    logic clr;

    uart_tx_fifo_if #(.WIDTH(8), .DEPTH(16)) bus ();

    uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .i_divided_clk (clk),
        .i_rst         (rst),
        .i_clear       (clr),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_q [$];
    bit         tx_auto  = 1'b0;
    bit         tx_latch = 1'b0;
    int         tx_busy  = 0;
    logic [7:0] tx_byte;
    int         rx_cnt   = 0;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       wr;
        logic [7:0] d;
        logic       nxt;
        logic [4:0] cnt;
        logic       full;
        logic       empty;
        logic       rdy;
        logic       ovf;
        logic [7:0] od;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance past the edge, then run the transmitter model on post-edge values.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (tx_auto) begin
            if (tx_latch) begin
                tx_latch   = 1'b0;
                bus.i_next = 1'b0;
                tx_busy    = 4;
                rx_cnt++;
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got byte %0h want none", tx_byte);
                end else begin
                    logic [7:0] e;
                    e = sb_q.pop_front();
                    total--;
                    chk("tx_byte", {24'd0, tx_byte}, {24'd0, e});
                end
            end else if (tx_busy > 0) begin
                tx_busy--;
                if (tx_busy == 0) bus.i_next = 1'b1;
            end else if (bus.i_next && bus.o_ready) begin
                tx_latch = 1'b1;
                tx_byte  = bus.o_data;
            end
        end
    endtask

    task automatic wr_cycle(input logic [7:0] d);
        bus.i_wr      = 1'b1;
        bus.i_wr_data = d;
        cyc();
        bus.i_wr      = 1'b0;
    endtask

    task automatic tx_start();
        tx_busy    = 0;
        tx_latch   = 1'b0;
        bus.i_next = 1'b1;
        tx_auto    = 1'b1;
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 3000; k++) begin
            if (sb_q.size() == 0 && bus.o_empty && !bus.o_ready && !tx_latch) break;
            cyc();
        end
        chk({nm, "_left"}, sb_q.size(), 32'd0);
        chk({nm, "_empty"}, {31'd0, bus.o_empty}, 32'd1);
        tx_auto  = 1'b0;
        tx_latch = 1'b0;
        tx_busy  = 0;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[8]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        vt[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        vt[11] = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        vt[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        vt[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
        vt[14] = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

        bus.i_wr      = 1'b0;
        bus.i_wr_data = 8'h00;
        bus.i_next    = 1'b0;
        rst           = 1'b1;
        clr           = 1'b0;

        // Reset, single-byte handshake, write+pop at count 3, clear mid-offer.
        for (int i = 0; i < 16; i++) begin
            rst           = vt[i].rst;
            clr           = vt[i].clr;
            bus.i_wr      = vt[i].wr;
            bus.i_wr_data = vt[i].d;
            bus.i_next    = vt[i].nxt;
            cyc();
            chk($sformatf("v%0d_count", i), {27'd0, bus.o_count}, {27'd0, vt[i].cnt});
            chk($sformatf("v%0d_full", i), {31'd0, bus.o_full}, {31'd0, vt[i].full});
            chk($sformatf("v%0d_empty", i), {31'd0, bus.o_empty}, {31'd0, vt[i].empty});
            chk($sformatf("v%0d_ready", i), {31'd0, bus.o_ready}, {31'd0, vt[i].rdy});
            chk($sformatf("v%0d_ovf", i), {31'd0, bus.o_overflow}, {31'd0, vt[i].ovf});
            chk($sformatf("v%0d_data", i), {24'd0, bus.o_data}, {24'd0, vt[i].od});
        end
        clr        = 1'b0;
        bus.i_wr   = 1'b0;
        bus.i_next = 1'b0;

        // Fill with transmitter stalled, then overflow with the 17th byte.
        for (int i = 0; i < 17; i++) begin
            wr_cycle(8'(i));
            if (i < 16) sb_q.push_back(8'(i));
            if (i == 15) begin
                chk("fill_full", {31'd0, bus.o_full}, 32'd1);
                chk("fill_ovf_pre", {31'd0, bus.o_overflow}, 32'd0);
            end
        end
        chk("ovf_count", {27'd0, bus.o_count}, 32'd16);
        chk("ovf_full", {31'd0, bus.o_full}, 32'd1);
        chk("ovf_flag", {31'd0, bus.o_overflow}, 32'd1);
        tx_start();
        drain("fill_drain");
        chk("fill_rx", rx_cnt, 32'd16);
        chk("ovf_sticky", {31'd0, bus.o_overflow}, 32'd1);

        // 40 bytes streamed through the pointer wrap.
        begin
            int sent;
            sent = 0;
            tx_start();
            for (int k = 0; k < 3000 && sent < 40; k++) begin
                if (bus.o_count < 5'd12) begin
                    logic [7:0] b;
                    b = 8'(sent * 37 + 5);
                    sb_q.push_back(b);
                    wr_cycle(b);
                    sent++;
                end else begin
                    cyc();
                end
            end
            chk("wrap_sent", sent, 32'd40);
            drain("wrap_drain");
            chk("wrap_rx", rx_cnt, 32'd56);
        end

        // Stalled transmitter: offer must hold with no pop.
        bus.i_next = 1'b1;
        wr_cycle(8'h5A);
        wr_cycle(8'h5B);
        wr_cycle(8'h5C);
        for (int k = 0; k < 50; k++) begin
            cyc();
            chk("stall_ready", {31'd0, bus.o_ready}, 32'd1);
            chk("stall_data", {24'd0, bus.o_data}, 32'h5A);
            chk("stall_count", {27'd0, bus.o_count}, 32'd3);
        end
        wr_cycle(8'h5D);
        wr_cycle(8'h5E);
        chk("pre_clr_count", {27'd0, bus.o_count}, 32'd5);
        chk("pre_clr_ovf", {31'd0, bus.o_overflow}, 32'd1);
        chk("pre_clr_ready", {31'd0, bus.o_ready}, 32'd1);

        // Clear mid-offer with a same-cycle write that must be ignored.
        clr           = 1'b1;
        bus.i_wr      = 1'b1;
        bus.i_wr_data = 8'hEE;
        cyc();
        clr      = 1'b0;
        bus.i_wr = 1'b0;
        chk("clr_ready", {31'd0, bus.o_ready}, 32'd0);
        chk("clr_count", {27'd0, bus.o_count}, 32'd0);
        chk("clr_ovf", {31'd0, bus.o_overflow}, 32'd0);
        chk("clr_data", {24'd0, bus.o_data}, 32'd0);
        cyc();
        chk("clr_wr_ignored", {27'd0, bus.o_count}, 32'd0);
        chk("clr_idle", {31'd0, bus.o_ready}, 32'd0);

        tx_start();
        sb_q.push_back(8'h77);
        wr_cycle(8'h77);
        drain("post_clr");
        chk("post_clr_rx", rx_cnt, 32'd57);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
